reg_bank_8: RTL and testbench
=============================

REG_BANK_8 -- requirements
Module: reg_bank_8

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port we, input, 1 bit: write enable.
REQ-004 The block SHALL have the port wa, input, 3 bits: write address, 0..7 selects A..H.
REQ-005 The block SHALL have the port wd, input, 16 bits: write data.
REQ-006 The block SHALL have the port inc, input, 1 bit: increment enable.
REQ-007 The block SHALL have the port ia, input, 3 bits: increment address, 0..7 selects A..H.
REQ-008 The block SHALL have the port clr, input, 1 bit: synchronous clear of all registers.
REQ-009 The block SHALL have the ports A, B, C, D, E, F, G, H, each an output of 16 bits: registers 0..7, wired directly to the data inputs of the downstream 8:1 16-bit operand mux.
REQ-010 The block SHALL have the port vld, output, 8 bits: per-register valid flags, where bit n corresponds to register n.

Function
REQ-011 The block SHALL hold eight 16-bit registers; each output A..H SHALL be driven directly from its register, with no combinational path from any input to any output.
REQ-012 On a clock edge with clr=1, all eight registers and all vld bits SHALL become 0, and we and inc SHALL be ignored that cycle.
REQ-013 On a clock edge with clr=0 and we=1, register[wa] SHALL load wd and vld[wa] SHALL become 1.
REQ-014 On a clock edge with clr=0 and inc=1, register[ia] SHALL load register[ia]+1, modulo 2^16: 0xFFFF wraps to 0x0000 with no carry out or flag.
REQ-015 An increment SHALL NOT change any vld bit.
REQ-016 When we=1, inc=1, and wa≠ia on the same edge, both the write and the increment SHALL take effect.
REQ-017 When we=1, inc=1, and wa=ia on the same edge, the write SHALL win: register[wa]=wd and the increment is dropped.
REQ-018 The write latency SHALL be one cycle: a value written on edge N SHALL appear on its output after edge N and remain there until the next write, increment, clear, or reset.
REQ-019 The increment latency SHALL be one cycle: an increment issued on edge N SHALL use the register value held before edge N.
REQ-020 Registers not addressed by a write or increment SHALL hold their value, and their vld bits SHALL hold.
REQ-021 Back-to-back increments to the same register on consecutive edges SHALL accumulate: k increments add k, modulo 2^16.
REQ-022 Writing a register whose vld bit is already 1 SHALL overwrite it, and vld SHALL remain 1.
REQ-023 X or Z on wa or ia while the corresponding enable is 0 SHALL NOT affect state.
REQ-024 Arithmetic SHALL be unsigned 16-bit, and no input or output SHALL be wider than specified.

Reset
REQ-025 When rst_n=0, all registers and all vld bits SHALL go to 0 immediately, independent of clk.
REQ-026 While rst_n=0, all clock edges SHALL be ignored, whatever the values of we, inc, and clr.
REQ-027 Deassertion of rst_n SHALL take effect cleanly at the next rising clk edge, with no spurious write on the deasserting edge unless we or inc is asserted.
REQ-028 Assertion of rst_n=0 while a write or increment is being requested SHALL discard that request; no partial update SHALL be visible after reset.

Verification
REQ-029 The bench SHALL cover reset and writes: rst_n=0 then 1; write wd=n+1 to wa=n for n=0..7 on consecutive edges. Required response: after the eighth edge A..H = 1..8 and vld = 0xFF.
REQ-030 The bench SHALL cover increment wrap: write C=0xFFFE, then inc ia=2 on three consecutive edges. Required response: C goes 0xFFFF, 0x0000, 0x0001; vld[2] stays 1; no other register changes.
REQ-031 The bench SHALL cover simultaneous write and increment: with D=0x0010, assert we with wa=3, wd=0x1234 and inc with ia=3 on the same edge. Required response: D=0x1234. Then assert we with wa=0, wd=0x00AA and inc with ia=3. Required response: A=0x00AA and D=0x1235.
REQ-032 The bench SHALL cover clear priority: with all registers loaded, assert clr=1, we=1 with wa=5, wd=0x5555, and inc=1 with ia=6. Required response: after the edge all A..H = 0 and vld = 0x00.
REQ-033 The bench SHALL cover asynchronous reset mid-operation: drive rst_n=0 between clock edges while we=1 with wa=7, wd=0xBEEF. Required response: all outputs go to 0 before the next edge, and H = 0 after that edge.
REQ-034 The bench SHALL cover the mux linkage: connect A..H to the downstream 8:1 16-bit operand mux after REQ-029 and sweep its select 0..7. Required response: the mux output equals select+1 at every select value.

Source files
------------

// File: rtl/reg_bank_8.sv
// Eight 16-bit registers with per-register valid flags, a write port and an
// increment port; clear and asynchronous reset dominate, write beats increment.
module reg_bank_8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd,
    input  logic        inc,
    input  logic [2:0]  ia,
    input  logic        clr,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [15:0] C,
    output logic [15:0] D,
    output logic [15:0] E,
    output logic [15:0] F,
    output logic [15:0] G,
    output logic [15:0] H,
    output logic [7:0]  vld
);

    localparam int unsigned NumRegs = 8;
    localparam int unsigned Width   = 16;

    logic [Width-1:0]   r_regs     [NumRegs];
    logic [NumRegs-1:0] r_vld;
    logic [Width-1:0]   w_regs_nxt [NumRegs];
    logic [NumRegs-1:0] w_vld_nxt;
    logic [NumRegs-1:0] w_wr_sel;
    logic [NumRegs-1:0] w_inc_sel;

    // Enables gate the address compare, so an undriven address with its enable low is harmless.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            w_wr_sel[i]  = we && (wa == 3'(i));
            w_inc_sel[i] = inc && (ia == 3'(i)) && !w_wr_sel[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            w_regs_nxt[i] = r_regs[i];
        end
        w_vld_nxt = r_vld;
        if (clr) begin
            for (int i = 0; i < NumRegs; i++) begin
                w_regs_nxt[i] = '0;
            end
            w_vld_nxt = '0;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                if (w_wr_sel[i]) begin
                    w_regs_nxt[i] = wd;
                    w_vld_nxt[i]  = 1'b1;
                end else if (w_inc_sel[i]) begin
                    // Wraps modulo 2^16; the carry is intentionally discarded.
                    w_regs_nxt[i] = r_regs[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
            r_vld <= '0;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= w_regs_nxt[i];
            end
            r_vld <= w_vld_nxt;
        end
    end

    assign A   = r_regs[0];
    assign B   = r_regs[1];
    assign C   = r_regs[2];
    assign D   = r_regs[3];
    assign E   = r_regs[4];
    assign F   = r_regs[5];
    assign G   = r_regs[6];
    assign H   = r_regs[7];
    assign vld = r_vld;

endmodule

// File: tb/tb_reg_bank_8.sv
// Directed and randomized bench for reg_bank_8, checked against an array model
// that applies the write/increment/clear rules directly.
module tb_reg_bank_8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        inc;
    logic [2:0]  ia;
    logic        clr;
    logic [15:0] A, B, C, D, E, F, G, H;
    logic [7:0]  vld;

    logic [15:0] outs [8];
    logic [2:0]  sel;
    logic [15:0] mux_out;

    int unsigned m_reg [8];
    bit          m_vld [8];
    int          n_checks = 0;
    int          n_errors = 0;

    reg_bank_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .inc   (inc),
        .ia    (ia),
        .clr   (clr),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .E     (E),
        .F     (F),
        .G     (G),
        .H     (H),
        .vld   (vld)
    );

    always #5 clk = ~clk;

    assign outs[0] = A;
    assign outs[1] = B;
    assign outs[2] = C;
    assign outs[3] = D;
    assign outs[4] = E;
    assign outs[5] = F;
    assign outs[6] = G;
    assign outs[7] = H;

    // Downstream 8:1 operand mux fed by A..H.
    always_comb begin
        case (sel)
            3'd0: mux_out = A;
            3'd1: mux_out = B;
            3'd2: mux_out = C;
            3'd3: mux_out = D;
            3'd4: mux_out = E;
            3'd5: mux_out = F;
            3'd6: mux_out = G;
            default: mux_out = H;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_vld();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_vld[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = 0;
            m_vld[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s reg%0d", tag, i), outs[i], 16'(m_reg[i]));
        end
        chk($sformatf("%s vld", tag), {8'h00, vld}, {8'h00, model_vld()});
    endtask

    // One clock edge with the given controls; model updated from the rules, then outputs checked.
    task automatic step(input logic s_we, input logic [2:0] s_wa, input logic [15:0] s_wd,
                        input logic s_inc, input logic [2:0] s_ia, input logic s_clr,
                        input string tag);
        @(negedge clk);
        we  = s_we;
        wa  = s_wa;
        wd  = s_wd;
        inc = s_inc;
        ia  = s_ia;
        clr = s_clr;
        @(posedge clk);
        if (s_clr) begin
            model_reset();
        end else begin
            if (s_inc && !(s_we && s_wa == s_ia)) m_reg[s_ia] = (m_reg[s_ia] + 1) % 65536;
            if (s_we) begin
                m_reg[s_wa] = s_wd;
                m_vld[s_wa] = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b1;
        wa    = 3'd4;
        wd    = 16'hDEAD;
        inc   = 1'b1;
        ia    = 3'd1;
        clr   = 1'b0;
        sel   = 3'd0;
        model_reset();

        // Edges during reset must be ignored even with enables high.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");

        @(negedge clk);
        we    = 1'b0;
        inc   = 1'b0;
        rst_n = 1'b1;
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, "deassert_idle");

        for (int n = 0; n < 8; n++) begin
            step(1'b1, 3'(n), 16'(n + 1), 1'b0, 3'd0, 1'b0, $sformatf("write%0d", n));
        end
        chk("vld_all", {8'h00, vld}, 16'h00FF);
        chk("H_is_8", H, 16'd8);

        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            chk($sformatf("mux_sel%0d", s), mux_out, 16'(s + 1));
        end

        step(1'b1, 3'd2, 16'hFFFE, 1'b0, 3'd0, 1'b0, "C_load");
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, "C_inc1");
        chk("C_ffff", C, 16'hFFFF);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, "C_inc2");
        chk("C_wrap", C, 16'h0000);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, "C_inc3");
        chk("C_0001", C, 16'h0001);
        chk("C_vld", {15'h0, vld[2]}, 16'h0001);

        step(1'b1, 3'd3, 16'h0010, 1'b0, 3'd0, 1'b0, "D_load");
        step(1'b1, 3'd3, 16'h1234, 1'b1, 3'd3, 1'b0, "wr_wins");
        chk("D_1234", D, 16'h1234);
        step(1'b1, 3'd0, 16'h00AA, 1'b1, 3'd3, 1'b0, "wr_and_inc");
        chk("A_00aa", A, 16'h00AA);
        chk("D_1235", D, 16'h1235);

        // Random mix; addresses wander while enables are low too.
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 31) == 0), $sformatf("rand%0d", k));
        end

        for (int n = 0; n < 8; n++) begin
            step(1'b1, 3'(n), 16'($urandom) | 16'h0001, 1'b0, 3'd0, 1'b0, "reload");
        end
        step(1'b1, 3'd5, 16'h5555, 1'b1, 3'd6, 1'b1, "clr_prio");
        chk("clr_vld", {8'h00, vld}, 16'h0000);
        chk("clr_F", F, 16'h0000);

        step(1'b1, 3'd7, 16'h1111, 1'b0, 3'd0, 1'b0, "H_load");
        @(negedge clk);
        we    = 1'b1;
        wa    = 3'd7;
        wd    = 16'hBEEF;
        inc   = 1'b1;
        ia    = 3'd7;
        clr   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        chk("H_after_edge", H, 16'h0000);
        check_all("rst_hold");

        @(negedge clk);
        we    = 1'b0;
        inc   = 1'b0;
        rst_n = 1'b1;
        step(1'b0, 3'd7, 16'hBEEF, 1'b0, 3'd7, 1'b0, "post_rst_idle");
        step(1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd0, 1'b0, "post_rst_write");
        chk("H_beef", H, 16'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
